// File: rtl/candy_sram_ctrl.sv
// Single-outstanding request/response front-end for candy_sram.
// Optional read watchdog enabled by defining CANDY_SRAM_CTRL_TIMEOUT_EN.
module candy_sram_ctrl #(
  parameter int ADDR_W         = 17,
  parameter int DATA_W         = 24,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              write_enable,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              read_enable,
  output logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rdata_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] resp_data_r;
  logic              resp_err_r;
  logic              accept_s;
  logic              timeout_s;

  assign req_ready = (state_r == IDLE) && rst;
  assign accept_s  = req_valid && req_ready;

`ifdef CANDY_SRAM_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt_r;

  // Watchdog: counts READ cycles without rdata_ready, cleared outside READ
  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r != READ) begin
      wd_cnt_r <= {CNT_W{1'b0}};
    end else if (!rdata_ready) begin
      wd_cnt_r <= wd_cnt_r + CNT_W'(1);
    end
  end

  // Limit is reached on the edge that would make the count TIMEOUT_CYCLES; data arriving then wins
  assign timeout_s = (state_r == READ) && !rdata_ready &&
                     (wd_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = req_we ? WRITE : READ;
        end else begin
          state_s = IDLE;
        end
      end
      WRITE: state_s = RESP;
      READ: begin
        if (rdata_ready || timeout_s) begin
          state_s = RESP;
        end else begin
          state_s = READ;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Request latch and response register
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_r      <= {ADDR_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      resp_data_r <= {DATA_W{1'b0}};
      resp_err_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
      end
      if (state_r == WRITE) begin
        resp_data_r <= {DATA_W{1'b0}};
        resp_err_r  <= 1'b0;
      end else if ((state_r == READ) && rdata_ready) begin
        resp_data_r <= rdata;
        resp_err_r  <= 1'b0;
      end else if (timeout_s) begin
        resp_data_r <= {DATA_W{1'b0}};
        resp_err_r  <= 1'b1;
      end
    end
  end

  // Strobes and buses decode straight from the state register, so reset drops them
  assign write_enable = (state_r == WRITE);
  assign read_enable  = (state_r == READ);
  assign waddr        = write_enable ? addr_r  : {ADDR_W{1'b0}};
  assign wdata        = write_enable ? wdata_r : {DATA_W{1'b0}};
  assign raddr        = read_enable  ? addr_r  : {ADDR_W{1'b0}};
  assign resp_valid   = (state_r == RESP);
  assign resp_rdata   = resp_data_r;
  assign resp_err     = resp_err_r;

endmodule

// File: doc/candy_sram_ctrl.md
# candy_sram_ctrl

Request/response front-end for `candy_sram`, placed directly upstream of it. It accepts single-word read and write requests from the core over a valid/ready handshake and sequences them onto the SRAM port (`write_enable`/`waddr`/`wdata`, `read_enable`/`raddr`). It waits for `rdata_ready` on reads and returns data or a write acknowledge over a valid/ready response channel. Only one transaction is in flight at a time. An optional watchdog aborts reads the SRAM never completes.

## Interface
Parameters:
- `ADDR_W`, default 17: address width; matches `SRAMAddrWidth`.
- `DATA_W`, default 24: data width; matches `SRAMDataWidth`.
- `TIMEOUT_CYCLES`, default 16: read watchdog limit, in cycles. Used only with `CANDY_SRAM_CTRL_TIMEOUT_EN`.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-low.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  core request present.
- `req_ready`  out  1  controller accepts a request this cycle.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  word address.
- `req_wdata`  in  DATA_W  write data.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  core takes the response.
- `resp_rdata`  out  DATA_W  read data; 0 for writes and errors.
- `resp_err`  out  1  read timed out.
- `write_enable`  out  1  SRAM write strobe.
- `waddr`  out  ADDR_W  SRAM write address.
- `wdata`  out  DATA_W  SRAM write data.
- `read_enable`  out  1  SRAM read request.
- `raddr`  out  ADDR_W  SRAM read address.
- `rdata`  in  DATA_W  SRAM read data.
- `rdata_ready`  in  1  `rdata` valid this cycle.

## Operation
- FSM states: IDLE, WRITE, READ, RESP. Reset state is IDLE.
- `req_ready` = (state == IDLE) && `rst`. It is combinational from registered state and never depends on `req_valid`.
- Accept occurs at an edge where `req_valid && req_ready` is 1. At that edge the controller latches `req_we`, `req_addr` and `req_wdata`.
  - Write: IDLE→WRITE.
  - Read: IDLE→READ.
- WRITE lasts exactly one cycle.
  - `write_enable`=1, with `waddr`/`wdata` driven from the latched values.
  - Then →RESP, with `resp_rdata`=0 and `resp_err`=0.
- READ:
  - `read_enable`=1 and `raddr` holds the latched address for the whole state.
  - `rdata_ready` is sampled every cycle, including the first.
  - When it is 1: capture `rdata` into the response register and →RESP.
- RESP:
  - `resp_valid`=1; response fields are held stable.
  - At an edge where `resp_ready`=1: →IDLE.
- SRAM strobes are never asserted outside WRITE/READ. The write and read strobes are never both 1.
- `waddr`/`wdata`/`raddr` are 0 whenever their strobe is 0.
- `rdata_ready` outside READ is ignored.
- A request held on `req_valid` while the controller is busy is not accepted. The core must hold it until `req_ready` is 1.

## Timing
- Reset value of every output is 0, including `req_ready` while `rst`=0. The latched address/data and response registers are cleared.
- Reset mid-transaction: at the reset edge the controller returns to IDLE and drops its strobes. The pending SRAM access and any pending response are discarded.
- Write, accepted at edge N:
  - `write_enable` is high only in cycle N+1.
  - `resp_valid` rises in cycle N+2.
  - The earliest next accept is at the edge ending the first `resp_ready` cycle, plus one cycle.
- Read, accepted at edge N:
  - `read_enable` rises in cycle N+1.
  - `rdata_ready` is first seen at edge M ≥ N+1.
  - `read_enable` drops and `resp_valid` rises in cycle M+1.
  - Minimum accept-to-response latency is 2 cycles.
- Back-to-back requests: the controller returns to IDLE one cycle after the response is taken. Throughput is at most one transaction per 3 cycles for writes and 3+ cycles for reads.

## Configuration
- Macro: `CANDY_SRAM_CTRL_TIMEOUT_EN`.
- Defined:
  - A counter clears on entry to READ and increments each READ cycle in which `rdata_ready`=0.
  - If it reaches `TIMEOUT_CYCLES`, the controller drops `read_enable` and →RESP with `resp_err`=1, `resp_rdata`=0.
  - `rdata_ready` arriving on the same cycle the limit is reached wins: the read returns normal data with `resp_err`=0.
- Not defined: no counter exists. READ waits indefinitely and `resp_err` is tied to 0.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `req_valid`=1 → all outputs 0, no SRAM strobe. After release, `req_ready`=1.
- Write 0x001234 to address 0, `resp_ready`=1 → `write_enable`=1 for exactly one cycle with `waddr`=0 and `wdata`=0x001234. `resp_valid`=1 one cycle later with `resp_rdata`=0.
- Read address 2 with the SRAM model asserting `rdata_ready` 3 cycles after `read_enable` and `rdata`=0xABCDEF → `raddr`=2 held for 3 cycles. Response 0xABCDEF, `resp_err`=0.
- Response back-pressure: hold `resp_ready`=0 for 4 cycles with a second request pending → `resp_valid` and data stay stable and `req_ready` stays 0. The second request is accepted only after the response is taken.
- Reset asserted during READ, second cycle → `read_enable`=0 on the next cycle and no `resp_valid`. A following read completes normally.
- With `CANDY_SRAM_CTRL_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, `rdata_ready` never asserted → `read_enable` drops after 16 cycles, then `resp_valid`=1, `resp_err`=1, `resp_rdata`=0.
